// File: rtl/if_pc_ctrl.sv
// Fetch sequencer: holds the architectural fetch PC, captures each fetched
// instruction into a one-entry slot handed to decode with valid/ready, and
// handles redirects, jalr operand stalls, fetch exceptions and debug halt.
module if_pc_ctrl #(
  parameter int                  PC_WIDTH    = 32,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = 32'h8000_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [PC_WIDTH-1:0]    pc_o,
  input  logic [PC_WIDTH-1:0]    if_pc_next_i,
  input  logic [INSTR_WIDTH-1:0] if_instr_i,
  input  logic                   if_jalr_rs1_en_i,
  input  logic                   jalr_rs1_busy_i,
  input  logic                   if_pc_misalign_i,
  input  logic                   if_bus_err_i,
  output logic                   id_valid_o,
  input  logic                   id_ready_i,
  output logic [PC_WIDTH-1:0]    id_pc_o,
  output logic [INSTR_WIDTH-1:0] id_instr_o,
  output logic [1:0]             id_exc_o,
  input  logic                   redirect_valid_i,
  input  logic [PC_WIDTH-1:0]    redirect_pc_i,
  input  logic                   halt_req_i,
  output logic                   halted_o
);

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_RUN,
    ST_WAIT_REDIR,
    ST_DRAIN,
    ST_HALT
  } state_e;

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic                   valid_q, valid_d;
  logic [PC_WIDTH-1:0]    id_pc_q, id_pc_d;
  logic [INSTR_WIDTH-1:0] id_instr_q, id_instr_d;
  logic [1:0]             id_exc_q, id_exc_d;
  logic                   halted_q, halted_d;

  logic       slot_free;
  logic       stall;
  logic [1:0] fetch_exc;

  assign slot_free = !valid_q || id_ready_i;
  assign stall     = if_jalr_rs1_en_i && jalr_rs1_busy_i;
  assign fetch_exc = {if_bus_err_i, if_pc_misalign_i};

  // Next-state, PC and output-slot update; redirect overrides everything but BOOT.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_exc_d   = id_exc_q;

    if (state_q != ST_BOOT && redirect_valid_i) begin
      // Flush the slot even if decode is taking it this cycle.
      pc_d    = redirect_pc_i;
      valid_d = 1'b0;
      if (state_q != ST_HALT) begin
        state_d = halt_req_i ? ST_DRAIN : ST_RUN;
      end
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_d = halt_req_i ? ST_DRAIN : ST_RUN;
        end
        ST_RUN: begin
          if (slot_free) begin
            valid_d = 1'b0;
          end
          if (halt_req_i) begin
            state_d = ST_DRAIN;
          end else if (slot_free && !stall) begin
            valid_d  = 1'b1;
            id_pc_d  = pc_q;
            id_exc_d = fetch_exc;
            if (fetch_exc != 2'b00) begin
              // Faulting fetch: deliver an empty packet, freeze PC until commit redirects.
              id_instr_d = '0;
              state_d    = ST_WAIT_REDIR;
            end else begin
              id_instr_d = if_instr_i;
              pc_d       = if_pc_next_i;
            end
          end
        end
        ST_WAIT_REDIR: begin
          if (id_ready_i) begin
            valid_d = 1'b0;
          end
        end
        ST_DRAIN: begin
          if (id_ready_i) begin
            valid_d = 1'b0;
          end
          if (!valid_q || id_ready_i) begin
            state_d = ST_HALT;
          end
        end
        ST_HALT: begin
          if (!halt_req_i) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_BOOT;
        end
      endcase
    end

    halted_d = (state_d == ST_HALT);
  end

  // State, PC and slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      id_pc_q    <= '0;
      id_instr_q <= '0;
      id_exc_q   <= 2'b00;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_exc_q   <= id_exc_d;
      halted_q   <= halted_d;
    end
  end

  assign pc_o       = pc_q;
  assign id_valid_o = valid_q;
  assign id_pc_o    = id_pc_q;
  assign id_instr_o = id_instr_q;
  assign id_exc_o   = id_exc_q;
  assign halted_o   = halted_q;

endmodule
